// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer for the RV32I core.
// Issues instruction-memory requests, keeps a one-entry skid buffer for words
// that arrive while decode is stalled, applies branch redirects and traps on
// misaligned branch targets.
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   seq_pc         pc_out + 4 from the external PC adder, used as given
//   branch_taken   one-cycle redirect request (highest priority)
//   branch_target  redirect address
//   stall          decode cannot accept a new instruction this cycle
//   imem_req       fetch request
//   imem_addr      fetch address (pc_out, except the stale address in DRAIN)
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     fetched word
//   pc_out         current fetch PC
//   inst_out       instruction to decode (NOP_INST when none is held)
//   inst_pc        PC of inst_out
//   inst_valid     inst_out is a real instruction
//   misaligned     sticky trap flag
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seq_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_TRAP
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_valid_q;
    logic        mis_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc_q;

    logic        tgt_misaligned;

    assign tgt_misaligned = (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            pc_q         <= RESET_VECTOR;
            drain_addr_q <= RESET_VECTOR;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= 32'd0;
        end else if (branch_taken && (state_q != S_TRAP)) begin
            // Redirect beats stall and any data returned this cycle.
            pc_q         <= branch_target;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= 32'd0;
            if (tgt_misaligned) begin
                mis_q <= 1'b1;
            end
            if ((state_q == S_FETCH) && !imem_ack) begin
                // Request still outstanding: finish it at the old address.
                state_q      <= S_DRAIN;
                drain_addr_q <= pc_q;
                req_q        <= 1'b1;
            end else if (state_q == S_DRAIN) begin
                // Keep draining the original stale request.
                state_q <= S_DRAIN;
                req_q   <= 1'b1;
            end else if (tgt_misaligned) begin
                state_q <= S_TRAP;
                req_q   <= 1'b0;
            end else begin
                state_q <= S_FETCH;
                req_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_q <= seq_pc;
                        if (!stall) begin
                            inst_q       <= imem_rdata;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                        end else begin
                            // Decode busy: park the word and stop fetching.
                            skid_inst_q <= imem_rdata;
                            skid_pc_q   <= pc_q;
                            state_q     <= S_HOLD;
                            req_q       <= 1'b0;
                        end
                    end else if (!stall) begin
                        inst_q       <= NOP_INST;
                        inst_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_q       <= skid_inst_q;
                        inst_pc_q    <= skid_pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_FETCH;
                        req_q        <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        // Stale data is dropped; a pending trap wins over fetch.
                        if (mis_q) begin
                            state_q <= S_TRAP;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_TRAP: begin
                    req_q        <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign pc_out     = pc_q;
    assign inst_out   = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed walk through reset, streaming, stall/skid, drain, branch+ack+stall,
// misaligned trap and asynchronous reset, followed by randomized traffic.
// A monitor process checks every presented instruction against the expected
// program-order stream: after presenting PC p the next one is p+4, unless a
// redirect was issued, in which case it is the branch target. Instruction
// words come from a fixed memory function of the address.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seq_pc;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        misaligned;

    always #5 clk = ~clk;

    // External PC adder.
    assign seq_pc = pc_out + 32'd4;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seq_pc       (seq_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .misaligned   (misaligned)
    );

    int vectors     = 0;
    int miscompares = 0;
    int mem_mode    = 0;   // 0: always ack, 1: never ack, 2: random ack
    int presented   = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Instruction memory: answers only live requests, one cycle at a time.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            imem_ack   = imem_req && ((mem_mode == 0) ||
                                      ((mem_mode == 2) && ($urandom_range(0, 99) < 60)));
            imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] exp_q[$];
    logic        exp_mis    = 1'b0;
    logic        req_dead   = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic [31:0] prev_addr  = 32'd0;
    logic [31:0] last_pc    = 32'd0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(32'h0000_0000);
            exp_mis    = 1'b0;
            req_dead   = 1'b0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            logic [31:0] e;
            chk("misaligned_flag", 32'(misaligned), 32'(exp_mis));
            if (exp_mis) begin
                chk("trap_inst_valid", 32'(inst_valid), 32'd0);
                if (req_dead) chk("trap_req_low", 32'(imem_req), 32'd0);
                if (!imem_req) req_dead = 1'b1;
            end
            if (prev_req && !prev_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (inst_valid) begin
                if (prev_valid && prev_stall) begin
                    chk("stall_hold_pc", inst_pc, last_pc);
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", inst_pc, e);
                    chk("stream_inst", inst_out, memf(e));
                    exp_q.push_back(e + 32'd4);
                    last_pc = inst_pc;
                    presented++;
                end
            end
            if (branch_taken && !exp_mis) begin
                exp_q.delete();
                exp_q.push_back(branch_target);
                if (branch_target[1:0] != 2'b00) exp_mis = 1'b1;
            end
            prev_valid = inst_valid;
            prev_stall = stall;
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_addr  = imem_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int trap_cnt;
        logic [31:0] t;
        int r;

        repeat (2) @(negedge clk);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_inst_out", inst_out, NOP);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        cyc(); rst_n = 1'b1;
        @(negedge clk); chk("idle_req", 32'(imem_req), 32'd0);
        cyc(); @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", 32'(inst_valid), 32'd0);
        cyc(); @(negedge clk);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_valid", 32'(inst_valid), 32'd1);
        chk("seq_inst0", inst_out, memf(32'h0));
        chk("seq_pc0", inst_pc, 32'h0);
        cyc(); stall = 1'b1; @(negedge clk);
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_inst4", inst_out, memf(32'h4));
        cyc(); @(negedge clk);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_pc_out", pc_out, 32'hC);
        chk("hold_inst", inst_out, memf(32'h4));
        cyc(); stall = 1'b0; @(negedge clk);
        chk("hold_still_inst", inst_out, memf(32'h4));
        cyc(); @(negedge clk);
        chk("release_inst", inst_out, memf(32'h8));
        chk("release_pc", inst_pc, 32'h8);
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", imem_addr, 32'hC);
        cyc(); mem_mode = 1; @(negedge clk);
        chk("pre_branch_addr", imem_addr, 32'h10);
        cyc(); branch_taken = 1'b1; branch_target = 32'h100; @(negedge clk);
        cyc(); branch_taken = 1'b0; @(negedge clk);
        chk("drain_pc_out", pc_out, 32'h100);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_valid", 32'(inst_valid), 32'd0);
        cyc(); mem_mode = 0; @(negedge clk);
        cyc(); @(negedge clk);
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_valid", 32'(inst_valid), 32'd0);
        cyc(); @(negedge clk);
        chk("target_inst", inst_out, memf(32'h100));
        cyc(); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; @(negedge clk);
        cyc(); stall = 1'b0; branch_taken = 1'b0; @(negedge clk);
        chk("bas_valid", 32'(inst_valid), 32'd0);
        chk("bas_inst", inst_out, NOP);
        chk("bas_addr", imem_addr, 32'h40);
        chk("bas_req", 32'(imem_req), 32'd1);
        cyc(); @(negedge clk);
        chk("bas_first_pc", inst_pc, 32'h40);
        cyc(); branch_taken = 1'b1; branch_target = 32'h102; @(negedge clk);
        cyc(); branch_target = 32'h200; @(negedge clk);
        chk("mis_pc_out", pc_out, 32'h102);
        chk("mis_req", 32'(imem_req), 32'd0);
        repeat (3) begin
            cyc(); @(negedge clk);
            chk("trap_pc_out", pc_out, 32'h102);
        end
        cyc(); branch_taken = 1'b0; rst_n = 1'b0; #1;
        chk("areset_pc_out", pc_out, 32'h0);
        chk("areset_mis", 32'(misaligned), 32'd0);
        cyc(); rst_n = 1'b1; @(negedge clk);
        chk("restart_idle_req", 32'(imem_req), 32'd0);
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        chk("restart_inst0", inst_out, memf(32'h0));
        #1 rst_n = 1'b0;
        #1;
        chk("pulse_req", 32'(imem_req), 32'd0);
        chk("pulse_addr", imem_addr, 32'h0);
        chk("pulse_inst", inst_out, NOP);
        chk("pulse_valid", 32'(inst_valid), 32'd0);
        chk("pulse_inst_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        cyc(); @(negedge clk);
        chk("pulse_restart_req", 32'(imem_req), 32'd1);
        chk("pulse_restart_addr", imem_addr, 32'h0);

        // Randomized traffic; the monitor does all checking here.
        presented = 0;
        trap_cnt  = 0;
        mem_mode  = 2;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if ((trap_cnt > 15) || ((c % 500) == 499)) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
                trap_cnt = 0;
            end
            stall        = ($urandom_range(0, 99) < 30);
            branch_taken = ($urandom_range(0, 99) < 8);
            r = $urandom_range(0, 99);
            t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (r < 5) t[1:0] = 2'($urandom_range(1, 3));
            else if (r < 15) t = 32'hFFFF_FFF0 | {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            branch_target = t;
            if (misaligned) trap_cnt++;
        end
        cyc(); branch_taken = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("random_liveness", 32'(presented >= 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
